// File: rtl/spibridge_pkg.sv
// Shared types and constants for the SPI frame bridge.
package spibridge_pkg;

    localparam int unsigned BITCNT_W = 16;

    localparam logic [1:0] MODE_CPOL_MASK = 2'b10;
    localparam logic [1:0] MODE_CPHA_MASK = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic logic mode_cpol(input int unsigned mode);
        return (2'(mode) & MODE_CPOL_MASK) != 2'b00;
    endfunction

    function automatic logic mode_cpha(input int unsigned mode);
        return (2'(mode) & MODE_CPHA_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a history flop; flags rising and falling edges of the synced level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic q_s1,
    output logic rise_c,
    output logic fall_c
);

    logic s1;
    logic s2;
    logic hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            hist <= RST_VAL;
        end else begin
            s1   <= d;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign q      = s2;
    assign q_s1   = s1;
    assign rise_c = s2 & ~hist;
    assign fall_c = ~s2 & hist;

endmodule

// File: rtl/spi_bridge_slave.sv
// SPI slave frame bridge: shifts one frame in/out per chip-select window, validates length
// and header, and raises a watchdog when good frames stop arriving.
module spi_bridge_slave
    import spibridge_pkg::*;
#(
    parameter int unsigned           FRAME_BITS   = 64,
    parameter int unsigned           MSGID_BITS   = 32,
    parameter logic [MSGID_BITS-1:0] MSGID        = 32'h74697277,
    parameter int unsigned           SPI_MODE     = 0,
    parameter logic [31:0]           TIMEOUT_CLKS = 32'd5000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  sel,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  tx_ack,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  err_len,
    output logic                  err_id,
    output logic                  timeout
);

    localparam logic                CPOL      = mode_cpol(SPI_MODE);
    localparam logic                CPHA      = mode_cpha(SPI_MODE);
    localparam logic [BITCNT_W-1:0] FRAME_CNT = BITCNT_W'(FRAME_BITS);

    logic sclk_lvl_unused, sclk_s1_unused, lead, trail;
    logic sel_s, sel_s1, sel_rise, sel_fall;
    logic mosi_s, mosi_s1_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk ^ CPOL), .q(sclk_lvl_unused),
        .q_s1(sclk_s1_unused), .rise_c(lead), .fall_c(trail)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sel (
        .clk(clk), .rst_n(rst_n), .d(sel), .q(sel_s),
        .q_s1(sel_s1), .rise_c(sel_rise), .fall_c(sel_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s),
        .q_s1(mosi_s1_unused), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
    );

    state_t                state, state_nxt;
    logic [FRAME_BITS-1:0] tx_sr, tx_sr_nxt, rx_sr, rx_sr_nxt, rx_data_nxt;
    logic [BITCNT_W-1:0]   bitcnt, bitcnt_nxt;
    logic                  fall_pend, fall_pend_nxt;
    logic                  tx_ack_nxt, rx_valid_nxt, err_len_nxt, err_id_nxt;
    logic [1:0]            sync_fill;
    logic                  armed;
    logic [31:0]           wd_cnt, wd_nxt;
    logic                  sample_c, shift_c, start_c;

    assign sample_c = CPHA ? trail : lead;
    assign shift_c  = CPHA ? lead : trail;
    // A fall only counts once sel has been seen high after reset and the pin is still low one stage back.
    assign start_c  = sel_fall & ~sel_s1 & armed;

    assign miso    = tx_sr[FRAME_BITS-1];
    assign miso_oe = ~sel_s;

    always_comb begin
        state_nxt     = state;
        tx_sr_nxt     = tx_sr;
        rx_sr_nxt     = rx_sr;
        bitcnt_nxt    = bitcnt;
        rx_data_nxt   = rx_data;
        fall_pend_nxt = fall_pend;
        tx_ack_nxt    = 1'b0;
        rx_valid_nxt  = 1'b0;
        err_len_nxt   = 1'b0;
        err_id_nxt    = 1'b0;
        case (state)
            IDLE: begin
                fall_pend_nxt = 1'b0;
                if (start_c || fall_pend) begin
                    state_nxt  = SHIFT;
                    tx_sr_nxt  = tx_data;
                    tx_ack_nxt = 1'b1;
                    bitcnt_nxt = '0;
                end
            end
            SHIFT: begin
                if (sel_rise) begin
                    state_nxt = CHECK;
                end else begin
                    if (sample_c) begin
                        rx_sr_nxt = {rx_sr[FRAME_BITS-2:0], mosi_s};
                        if (bitcnt != '1) bitcnt_nxt = bitcnt + BITCNT_W'(1);
                    end
                    // In CPHA=1 the first leading edge only presents the already-loaded MSB.
                    if (shift_c && !(CPHA && bitcnt == '0)) begin
                        tx_sr_nxt = {tx_sr[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            CHECK: begin
                state_nxt     = IDLE;
                fall_pend_nxt = start_c;
                if (bitcnt != FRAME_CNT) begin
                    err_len_nxt = 1'b1;
                end else if (rx_sr[FRAME_BITS-1 -: MSGID_BITS] != MSGID) begin
                    err_id_nxt = 1'b1;
                end else begin
                    rx_data_nxt  = rx_sr;
                    rx_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bitcnt    <= '0;
            fall_pend <= 1'b0;
            rx_data   <= '0;
            tx_ack    <= 1'b0;
            rx_valid  <= 1'b0;
            err_len   <= 1'b0;
            err_id    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_sr     <= tx_sr_nxt;
            rx_sr     <= rx_sr_nxt;
            bitcnt    <= bitcnt_nxt;
            fall_pend <= fall_pend_nxt;
            rx_data   <= rx_data_nxt;
            tx_ack    <= tx_ack_nxt;
            rx_valid  <= rx_valid_nxt;
            err_len   <= err_len_nxt;
            err_id    <= err_id_nxt;
        end
    end

    // Arming: a frame may start only after sel has been observed inactive since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & sel_s);
        end
    end

    always_comb begin
        wd_nxt = wd_cnt;
        if (rx_valid_nxt) begin
            wd_nxt = '0;
        end else if (wd_cnt != TIMEOUT_CLKS) begin
            wd_nxt = wd_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt  <= wd_nxt;
            timeout <= (TIMEOUT_CLKS != 32'd0) && (wd_nxt == TIMEOUT_CLKS);
        end
    end

endmodule

// File: tb/tb_spi_bridge_slave.sv
// Bench for spi_bridge_slave: one DUT per SPI mode, master tasks drive frames, scoreboard checks results.
module tb_spi_bridge_slave;

    localparam int FB   = 64;
    localparam int HALF = 6;
    localparam logic [63:0] GOOD  = 64'h74697277_DEADBEEF;
    localparam logic [63:0] GOOD2 = 64'h74697277_0BADF00D;
    localparam logic [63:0] BADID = 64'h74697278_DEADBEEF;
    localparam logic [63:0] TX1   = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] TX2   = 64'h1234_5678_9ABC_DEF0;

    typedef struct {
        int          mode;
        logic [2:0]  kind;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk [4];
    logic sel [4];
    logic mosi [4];
    logic miso [4];
    logic miso_oe [4];
    logic tx_ack [4];
    logic rx_valid [4];
    logic err_len [4];
    logic err_id [4];
    logic timeout [4];
    logic [FB-1:0] rx_data [4];
    logic [FB-1:0] tx_data;

    int          vectors = 0;
    int          miscompares = 0;
    int          tx_acks [4] = '{0, 0, 0, 0};
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] last_good [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
    logic        tmo_at_valid;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_bridge_slave #(
            .FRAME_BITS(FB), .MSGID_BITS(32), .MSGID(32'h74697277),
            .SPI_MODE(m), .TIMEOUT_CLKS(32'd100)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .sclk(sclk[m]), .sel(sel[m]), .mosi(mosi[m]),
            .miso(miso[m]), .miso_oe(miso_oe[m]), .tx_data(tx_data), .tx_ack(tx_ack[m]),
            .rx_data(rx_data[m]), .rx_valid(rx_valid[m]), .err_len(err_len[m]),
            .err_id(err_id[m]), .timeout(timeout[m])
        );
    end

    // Scoreboard: every result pulse pops the oldest expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int m = 0; m < 4; m++) begin
                if (tx_ack[m] === 1'b1) tx_acks[m]++;
                if (rx_valid[m] || err_len[m] || err_id[m]) begin
                    vectors++;
                    if (rx_valid[m]) tmo_at_valid = timeout[m];
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_event mode=%0d got {id,len,valid}=%b", m,
                                 {err_id[m], err_len[m], rx_valid[m]});
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.mode != m || mon_e.kind !== {err_id[m], err_len[m], rx_valid[m]} ||
                            rx_data[m] !== mon_e.data) begin
                            miscompares++;
                            $display("FAIL scoreboard mode got %0d exp %0d, kind got %b exp %b, rx_data got %h exp %h",
                                     m, mon_e.mode, {err_id[m], err_len[m], rx_valid[m]}, mon_e.kind,
                                     rx_data[m], mon_e.data);
                        end
                    end
                end
            end
        end
    end

    // Master side of one frame; caller is at a negedge. abort_at>=0 resets the DUTs at that bit.
    task automatic spi_frame(input int m, input int nbits, input logic [127:0] bits,
                             input logic [63:0] txd, input logic [2:0] exp_kind,
                             input int abort_at, input bit quick);
        logic [1:0]   md = 2'(m);
        logic         cpol = md[1];
        logic         cpha = md[0];
        logic [127:0] miso_bits = '0;
        logic [127:0] exp_miso = '0;
        int           ack0 = tx_acks[m];
        if (exp_kind == 3'b001) last_good[m] = bits[63:0];
        if (exp_kind != 3'b000) exp_q.push_back('{m, exp_kind, last_good[m]});
        tx_data = txd;
        sel[m] = 1'b0;
        if (!cpha) mosi[m] = bits[nbits-1];
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF) @(negedge clk);
            if (i == abort_at) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                vectors++;
                if ({miso[m], miso_oe[m], tx_ack[m], rx_valid[m], err_len[m], err_id[m]} !== 6'b0 ||
                    rx_data[m] !== '0) begin
                    miscompares++;
                    $display("FAIL reset_mid_frame outputs got rx_data=%h miso_oe=%b exp all 0", rx_data[m], miso_oe[m]);
                end
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) last_good[k] = '0;
                repeat (HALF) @(negedge clk);
                sel[m] = 1'b1;
                repeat (8) @(negedge clk);
                return;
            end
            if (i == 0) begin
                vectors++;
                if (miso_oe[m] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL miso_oe mode=%0d got %b exp 1", m, miso_oe[m]);
                end
            end
            if (!cpha) miso_bits[nbits-1-i] = miso[m];
            else       mosi[m] = bits[nbits-1-i];
            sclk[m] = ~cpol;
            repeat (HALF) @(negedge clk);
            if (cpha) miso_bits[nbits-1-i] = miso[m];
            sclk[m] = cpol;
            if (!cpha && i < nbits - 1) mosi[m] = bits[nbits-2-i];
        end
        repeat (HALF) @(negedge clk);
        sel[m] = 1'b1;
        for (int i = 0; i < nbits; i++) exp_miso[nbits-1-i] = (i < 64) ? txd[63-i] : 1'b0;
        vectors++;
        if (miso_bits !== exp_miso) begin
            miscompares++;
            $display("FAIL miso_stream mode=%0d got %h exp %h", m, miso_bits, exp_miso);
        end
        if (quick) begin
            @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
            vectors++;
            if ({err_id[m], err_len[m], rx_valid[m]} !== 3'b000) begin
                miscompares++;
                $display("FAIL early_result mode=%0d got %b exp 000", m, {err_id[m], err_len[m], rx_valid[m]});
            end
            @(negedge clk);
            vectors++;
            if ({err_id[m], err_len[m], rx_valid[m]} !== exp_kind) begin
                miscompares++;
                $display("FAIL latency mode=%0d got %b exp %b", m, {err_id[m], err_len[m], rx_valid[m]}, exp_kind);
            end
        end
        vectors++;
        if (tx_acks[m] != ack0 + 1) begin
            miscompares++;
            $display("FAIL tx_ack_count mode=%0d got %0d exp %0d", m, tx_acks[m] - ack0, 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tx_data = '0;
        for (int m = 0; m < 4; m++) begin
            sclk[m] = (m >= 2);
            sel[m]  = 1'b1;
            mosi[m] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if ({miso[m], miso_oe[m], tx_ack[m], rx_valid[m], err_len[m], err_id[m], timeout[m]} !== 7'b0 ||
                rx_data[m] !== '0) begin
                miscompares++;
                $display("FAIL reset_state mode=%0d got %b rx_data=%h exp 0", m,
                         {miso[m], miso_oe[m], tx_ack[m], rx_valid[m], err_len[m], err_id[m], timeout[m]}, rx_data[m]);
            end
        end
    endtask

    task automatic test_timeout();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) last_good[k] = '0;
        repeat (99) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if (timeout[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_cycle99 mode=%0d got %b exp 0", m, timeout[m]);
            end
        end
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if (timeout[m] !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout_cycle100 mode=%0d got %b exp 1", m, timeout[m]);
            end
        end
        tmo_at_valid = 1'bx;
        spi_frame(0, 64, {64'd0, GOOD}, TX1, 3'b001, -1, 1'b0);
        @(negedge clk);
        vectors++;
        if (tmo_at_valid !== 1'b0 || timeout[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear got at_valid=%b after=%b exp 0 0", tmo_at_valid, timeout[0]);
        end
    endtask

    task automatic test_good_frame();
        for (int m = 0; m < 4; m++) spi_frame(m, 64, {64'd0, GOOD}, TX1, 3'b001, -1, 1'b0);
    endtask

    task automatic test_len_err();
        spi_frame(0, 63, {65'd0, GOOD[63:1]}, TX2, 3'b010, -1, 1'b0);
        spi_frame(1, 65, {63'd0, GOOD, 1'b1}, TX2, 3'b010, -1, 1'b0);
    endtask

    task automatic test_id_err();
        spi_frame(2, 64, {64'd0, BADID}, TX2, 3'b100, -1, 1'b0);
        vectors++;
        if (timeout[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_after_err_id got %b exp 1", timeout[2]);
        end
    endtask

    task automatic test_glitch();
        int ack0 = tx_acks[0];
        sel[0] = 1'b0;
        @(negedge clk);
        sel[0] = 1'b1;
        repeat (12) @(negedge clk);
        vectors++;
        if (tx_acks[0] != ack0) begin
            miscompares++;
            $display("FAIL sel_glitch tx_ack got %0d exp 0", tx_acks[0] - ack0);
        end
    endtask

    task automatic test_reset_mid_frame();
        spi_frame(0, 64, {64'd0, GOOD2}, TX2, 3'b000, 20, 1'b0);
        spi_frame(0, 64, {64'd0, GOOD2}, TX2, 3'b001, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        spi_frame(3, 64, {64'd0, GOOD}, TX1, 3'b001, -1, 1'b1);
        spi_frame(3, 64, {64'd0, GOOD2}, TX2, 3'b001, -1, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_timeout();
        test_good_frame();
        test_len_err();
        test_id_err();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (10) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_events got %0d outstanding exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
